// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory stalls and timeout.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
   parameter int unsigned BR_FLUSH_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_taken,
   input  logic        exe_mem_read,
   input  logic [4:0]  exe_dest,
   input  logic [4:0]  id_src1,
   input  logic [4:0]  id_src2,
   input  logic        id_two_src,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        freeze_if,
   output logic        freeze_exe,
   output logic        flush_if_id,
   output logic        flush_id_exe,
   output logic        mem_timeout
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   typedef enum logic [1:0] {StRun, StFlush, StHalt} state_t;

   localparam logic [2:0] FlushInit    = 3'(BR_FLUSH_CYCLES - 1);
   localparam logic [7:0] TimeoutLast  = 8'(MEM_TIMEOUT - 1);
   localparam bit         MultiFlush   = (BR_FLUSH_CYCLES > 1);

   state_t     state_q;
   logic [2:0] flush_left_q;
   logic [7:0] wait_cnt_q;
   logic       timeout_q;

   logic mem_stall;
   logic load_use;
   logic timeout_hit;
   logic br_accept;

   assign mem_stall   = mem_req && !mem_ready && (state_q != StHalt);
   assign load_use    = exe_mem_read && (exe_dest != 5'd0) &&
                        ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
   assign timeout_hit = mem_stall && (wait_cnt_q == TimeoutLast);
   assign br_accept   = (state_q == StRun) && !mem_stall && br_taken;

   // Outputs are decoded combinationally so hazards act in the same cycle they appear;
   // rst masks them so nothing leaks out while reset is held.
   always_comb begin
      freeze_if    = 1'b0;
      freeze_exe   = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_exe = 1'b0;
      mem_timeout  = 1'b0;
      if (!rst) begin
         mem_timeout = timeout_q;
         unique case (state_q)
            StRun: begin
               if (mem_stall) begin
                  freeze_if  = 1'b1;
                  freeze_exe = 1'b1;
               end else if (br_taken) begin
                  flush_if_id  = 1'b1;
                  flush_id_exe = 1'b1;
               end else if (load_use) begin
                  freeze_if    = 1'b1;
                  flush_id_exe = 1'b1;
               end
            end
            StFlush: begin
               if (mem_stall) begin
                  freeze_if  = 1'b1;
                  freeze_exe = 1'b1;
               end else begin
                  flush_if_id  = 1'b1;
                  flush_id_exe = 1'b1;
               end
            end
            StHalt: begin
               freeze_if  = 1'b1;
               freeze_exe = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRun;
         flush_left_q <= 3'd0;
         wait_cnt_q   <= 8'd0;
         timeout_q    <= 1'b0;
      end else begin
         wait_cnt_q <= mem_stall ? (wait_cnt_q + 8'd1) : 8'd0;
         unique case (state_q)
            StRun: begin
               if (mem_stall) begin
                  if (timeout_hit) begin
                     state_q   <= StHalt;
                     timeout_q <= 1'b1;
                  end
               end else if (br_taken && MultiFlush) begin
                  state_q      <= StFlush;
                  flush_left_q <= FlushInit;
               end
            end
            StFlush: begin
               if (mem_stall) begin
                  if (timeout_hit) begin
                     state_q   <= StHalt;
                     timeout_q <= 1'b1;
                  end
               end else begin
                  flush_left_q <= flush_left_q - 3'd1;
                  if (flush_left_q == 3'd1) begin
                     state_q <= StRun;
                  end
               end
            end
            StHalt: ;
            default: state_q <= StRun;
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (freeze_if && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (br_accept && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;
`else
   logic unused_br_accept;
   assign unused_br_accept = br_accept;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters (name, default, meaning): BR_FLUSH_CYCLES, 1, cycles flush held after a taken branch (1..7); MEM_TIMEOUT, 255, max consecutive memory-stall cycles (1..255).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 br_taken  in  1  EXE-stage branch resolved taken.
REQ-005 exe_mem_read  in  1  instruction in EXE is a load.
REQ-006 exe_dest  in  5  EXE destination register.
REQ-007 id_src1, id_src2  in  5 each  ID source registers.
REQ-008 id_two_src  in  1  ID instruction reads id_src2.
REQ-009 mem_req  in  1  MEM stage has a load/store in flight.
REQ-010 mem_ready  in  1  memory completes access this cycle.
REQ-011 freeze_if  out  1  hold PC and IF/ID register.
REQ-012 freeze_exe  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
REQ-013 flush_if_id  out  1  clear IF/ID to bubble.
REQ-014 flush_id_exe  out  1  clear ID/EXE to bubble (drives ID/EXE flush input).
REQ-015 mem_timeout  out  1  sticky memory-timeout error.

Function
REQ-016 FSM states SHALL be RUN, FLUSH, HALT; outputs combinational from state, counters and inputs.
REQ-017 mem_stall SHALL be mem_req AND NOT mem_ready in RUN or FLUSH.
REQ-018 mem_stall: freeze_if=1, freeze_exe=1, both flush outputs 0, FSM state and flush counter hold.
REQ-019 load_use SHALL be exe_mem_read AND exe_dest!=0 AND (exe_dest==id_src1 OR (id_two_src AND exe_dest==id_src2)).
REQ-020 RUN, no mem_stall, load_use: freeze_if=1, flush_id_exe=1, freeze_exe=0, flush_if_id=0 (one bubble per cycle of hazard).
REQ-021 RUN, no mem_stall, br_taken: flush_if_id=1, flush_id_exe=1 same cycle, freezes 0; if BR_FLUSH_CYCLES>1 go to FLUSH with flush_left=BR_FLUSH_CYCLES-1, else stay RUN.
REQ-022 Priority in RUN: mem_stall > br_taken > load_use; br_taken during mem_stall SHALL be ignored (EXE held, re-presented after stall).
REQ-023 FLUSH, no mem_stall: flush_if_id=1, flush_id_exe=1, flush_left decrements; return to RUN on the cycle flush_left reaches 0 after decrement; br_taken and load_use ignored.
REQ-024 wait_cnt (8 bits) SHALL increment each mem_stall cycle, clear on any non-stall cycle.
REQ-025 mem_stall with wait_cnt==MEM_TIMEOUT-1: next state HALT, mem_timeout set.
REQ-026 HALT: freeze_if=1, freeze_exe=1, flushes 0, mem_timeout=1; exits only on rst.
REQ-027 No stall/hazard/branch in RUN: all outputs 0.

Reset
REQ-028 rst=1 SHALL asynchronously force state RUN, flush_left=0, wait_cnt=0, mem_timeout=0.
REQ-029 While rst=1 all outputs SHALL be 0 regardless of inputs; reset mid-stall or mid-flush abandons it, no residual flush on release.

Configuration
REQ-030 Macro PIPE_PERF_CNT_EN defined: add outputs stall_cycles (32, out) and flush_events (32, out), reset 0.
REQ-031 stall_cycles SHALL increment each cycle freeze_if=1 (any cause, including HALT), saturating at 32'hFFFFFFFF.
REQ-032 flush_events SHALL increment once per accepted br_taken (REQ-021), saturating.
REQ-033 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-034 exe_mem_read=1, exe_dest=5, id_src1=5, one cycle -> freeze_if=1, flush_id_exe=1, freeze_exe=0; exe_dest=0 same case -> all 0.
REQ-035 BR_FLUSH_CYCLES=3, br_taken pulse -> flush_if_id=flush_id_exe=1 for exactly 3 cycles, then RUN.
REQ-036 mem_req=1, mem_ready=0 for 4 cycles with br_taken=1 -> freeze_if=freeze_exe=1, no flush for 4 cycles; mem_ready=1 -> flush next evaluated.
REQ-037 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> HALT after 4th stall cycle, mem_timeout=1 sticky until rst.
REQ-038 rst asserted mid-FLUSH (flush_left=2) -> outputs 0 immediately; after release no flush asserted.
REQ-039 PIPE_PERF_CNT_EN: 2 load-use cycles + 3 mem-stall cycles + 1 branch -> stall_cycles=5, flush_events=1.
